bp_fe_fetch_queue: RTL and testbench

BP_FE_FETCH_QUEUE -- requirements
Module: bp_fe_fetch_queue

---
 rtl/bp_fe_fetch_queue.sv | 136 +++++++++++++
 tb/tb_bp_fe_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_fetch_queue.sv
// Fetch queue between the frontend realigner and the backend issue logic.
// Latency: an accepted entry is visible at the head one cycle later (no bypass).
// Backpressure: fetch_ready_o drops when full; a same-cycle dequeue does not reopen it.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   redirect_v_i              backend redirect, flushes every queued entry
//   fetch_*_i / fetch_ready_o enqueue side: pc, instr, exception flag, partial flag
//   deq_*_o / deq_yumi_i      dequeue side: head entry and consumer take
//   count_o                   occupancy, 0..els_p

package bp_fe_fetch_queue_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  localparam int instr_width_gp = 32;

  // Virtual address width carried by each processor configuration.
  function automatic int vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

endpackage

module bp_fe_fetch_queue
  import bp_fe_fetch_queue_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         els_p       = 4,
  localparam int        vaddr_width_p = vaddr_width(bp_params_p),
  localparam int        ptr_w_lp      = $clog2(els_p),
  localparam int        cnt_w_lp      = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      redirect_v_i,

  input  logic                      fetch_v_i,
  input  logic [vaddr_width_p-1:0]  fetch_pc_i,
  input  logic [instr_width_gp-1:0] fetch_instr_i,
  input  logic                      fetch_exception_v_i,
  input  logic                      fetch_partial_i,
  output logic                      fetch_ready_o,

  output logic                      deq_v_o,
  output logic [vaddr_width_p-1:0]  deq_pc_o,
  output logic [instr_width_gp-1:0] deq_instr_o,
  output logic                      deq_exception_v_o,
  output logic                      deq_partial_o,
  input  logic                      deq_yumi_i,

  output logic [cnt_w_lp-1:0]       count_o
);

  typedef struct packed {
    logic [vaddr_width_p-1:0]  pc;
    logic [instr_width_gp-1:0] instr;
    logic                      exception_v;
    logic                      partial;
  } entry_t;

  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  entry_t              mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  logic enq_fire, deq_fire;

  // Handshakes depend only on registered occupancy, so ready/valid never
  // combinationally depend on the opposite side of the queue.
  assign fetch_ready_o = (count_q != full_cnt_lp);
  assign deq_v_o       = (count_q != '0);
  assign count_o       = count_q;

  // A redirect cycle kills both transfers even though ready/valid still
  // show the pre-flush state.
  assign enq_fire = fetch_v_i  & fetch_ready_o & ~redirect_v_i;
  assign deq_fire = deq_yumi_i & deq_v_o       & ~redirect_v_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_v_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (enq_fire) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + cnt_w_lp'(1);
        2'b01:   count_d = count_q - cnt_w_lp'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; head contents are meaningless while
  // deq_v_o is low.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      mem_q[wr_ptr_q] <= '{pc:          fetch_pc_i,
                           instr:       fetch_instr_i,
                           exception_v: fetch_exception_v_i,
                           partial:     fetch_partial_i};
    end
  end

  assign deq_pc_o          = mem_q[rd_ptr_q].pc;
  assign deq_instr_o       = mem_q[rd_ptr_q].instr;
  assign deq_exception_v_o = mem_q[rd_ptr_q].exception_v;
  assign deq_partial_o     = mem_q[rd_ptr_q].partial;

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Self-checking bench for bp_fe_fetch_queue: directed scenarios followed by
// random traffic, checked against a queue-based occupancy/ordering model.
module tb_bp_fe_fetch_queue;

  localparam int ELS = 4;
  localparam int VA  = 39;
  localparam int IW  = 32;

  typedef struct {
    logic [VA-1:0] pc;
    logic [IW-1:0] instr;
    logic          exc;
    logic          part;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          redirect_v_i;
  logic          fetch_v_i;
  logic [VA-1:0] fetch_pc_i;
  logic [IW-1:0] fetch_instr_i;
  logic          fetch_exception_v_i;
  logic          fetch_partial_i;
  logic          fetch_ready_o;
  logic          deq_v_o;
  logic [VA-1:0] deq_pc_o;
  logic [IW-1:0] deq_instr_o;
  logic          deq_exception_v_o;
  logic          deq_partial_o;
  logic          deq_yumi_i;
  logic [2:0]    count_o;

  bp_fe_fetch_queue #(.els_p(ELS)) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .redirect_v_i        (redirect_v_i),
    .fetch_v_i           (fetch_v_i),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_instr_i       (fetch_instr_i),
    .fetch_exception_v_i (fetch_exception_v_i),
    .fetch_partial_i     (fetch_partial_i),
    .fetch_ready_o       (fetch_ready_o),
    .deq_v_o             (deq_v_o),
    .deq_pc_o            (deq_pc_o),
    .deq_instr_o         (deq_instr_o),
    .deq_exception_v_o   (deq_exception_v_o),
    .deq_partial_o       (deq_partial_o),
    .deq_yumi_i          (deq_yumi_i),
    .count_o             (count_o)
  );

  always #5 clk = ~clk;

  // Model state: occupancy visible this cycle, occupancy after this cycle,
  // and the expected FIFO contents (head at index 0).
  exp_t exp_q[$];
  int   cur_count  = 0;
  int   next_count = 0;
  logic acc_deq    = 1'b0;
  logic flush_pend = 1'b0;
  logic acc_enq    = 1'b0;
  logic mon_en     = 1'b0;
  int   checks     = 0;
  int   fails      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus. The model decides acceptance from its own
  // occupancy, never from the DUT.
  task automatic step(input logic v, input logic [VA-1:0] pc, input logic [IW-1:0] ins,
                      input logic exc, input logic part, input logic yumi,
                      input logic redir, input logic rst);
    @(posedge clk);
    #1;
    cur_count           = next_count;
    fetch_v_i           = v;
    fetch_pc_i          = pc;
    fetch_instr_i       = ins;
    fetch_exception_v_i = exc;
    fetch_partial_i     = part;
    deq_yumi_i          = yumi;
    redirect_v_i        = redir;
    reset_i             = rst;
    acc_enq    = v    && (cur_count != ELS) && !redir && !rst;
    acc_deq    = yumi && (cur_count != 0)   && !redir && !rst;
    flush_pend = redir || rst;
    if (acc_enq) exp_q.push_back('{pc: pc, instr: ins, exc: exc, part: part});
    if (flush_pend) next_count = 0;
    else            next_count = cur_count + int'(acc_enq) - int'(acc_deq);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [VA-1:0] pc, input logic exc, input logic part);
    step(1'b1, pc, $urandom(), exc, part, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic yumi();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compares handshakes and head contents every cycle, retires the
  // head on an accepted dequeue, and discards the model on flush/reset.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 64'(count_o), 64'(cur_count));
      chk("fetch_ready", 64'(fetch_ready_o), 64'(cur_count != ELS));
      chk("deq_v", 64'(deq_v_o), 64'(cur_count != 0));
      if (cur_count != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL head_model: got empty scoreboard expected %0d entries", cur_count);
        end else begin
          chk("head_pc", 64'(deq_pc_o), 64'(exp_q[0].pc));
          chk("head_exc", 64'(deq_exception_v_o), 64'(exp_q[0].exc));
          chk("head_partial", 64'(deq_partial_o), 64'(exp_q[0].part));
          if (!exp_q[0].exc) chk("head_instr", 64'(deq_instr_o), 64'(exp_q[0].instr));
        end
      end
      if (deq_yumi_i && cur_count == 0 && !reset_i && !redirect_v_i) begin
        checks++;
        fails++;
        $display("FAIL yumi_protocol: got yumi with empty queue expected no yumi");
      end
      if (acc_deq && exp_q.size() != 0) void'(exp_q.pop_front());
      if (flush_pend) exp_q.delete();
    end
  end

  initial begin
    int i;
    reset_i = 1'b1; redirect_v_i = 1'b0; fetch_v_i = 1'b0; deq_yumi_i = 1'b0;
    fetch_pc_i = '0; fetch_instr_i = '0; fetch_exception_v_i = 1'b0; fetch_partial_i = 1'b0;

    // Reset held for two cycles; checking starts once reset has been sampled.
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // Fill to capacity, then full with simultaneous offer and take.
    for (int k = 0; k < 4; k++) enq(VA'(32'h1000 + 4 * k), 1'b0, 1'b0);
    idle();
    step(1'b1, VA'(32'h1010), 32'hdead_beef, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) yumi();
    idle();

    // Wrap: ten entries through a four-deep queue, upstream holding on stall.
    i = 0;
    while (i < 10) begin
      step(1'b1, VA'(32'h2000 + 4 * i), $urandom(), 1'b0, 1'b0,
           (next_count != 0) && ($urandom_range(0, 2) != 0), 1'b0, 1'b0);
      if (acc_enq) i++;
    end
    while (next_count != 0) yumi();
    idle();

    // Flush with every input active, then a fresh entry becomes the head.
    for (int k = 0; k < 3; k++) enq(VA'(32'h30a0 + 4 * k), 1'b0, 1'b0);
    step(1'b1, VA'(32'h3100), $urandom(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    enq(VA'(32'h3000), 1'b0, 1'b0);
    idle();
    yumi();

    // Partial then exception entries keep their flags and order.
    enq(VA'(32'h4002), 1'b0, 1'b1);
    enq(VA'(32'h4006), 1'b1, 1'b0);
    yumi();
    yumi();
    idle();

    // Reset in the middle of traffic.
    enq(VA'(32'h5000), 1'b0, 1'b0);
    enq(VA'(32'h5004), 1'b0, 1'b0);
    step(1'b1, VA'(32'h5008), $urandom(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // Random traffic with occasional redirects and resets.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7,
           VA'({$urandom(), $urandom()}),
           $urandom(),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1,
           (next_count != 0) && ($urandom_range(0, 1) == 1),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 49) == 0);
    end
    idle();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
